cdb_complete_arbiter: RTL and testbench
=======================================

Name: cdb_complete_arbiter

Overview:
- Parametrised completion stage that replaces fixed per-FU CDB grant wiring.
- Accepts results from NUM_FU functional units through valid/ready handshakes. Each unit's results are held in a private FIFO of depth BUF_DEPTH.
- Each cycle, up to N results are granted onto N registered CDB lanes using round-robin priority.
- Results that depend on a mispredicted branch are squashed, and branch-mask bits are cleared on correct resolution.

Parameters:
- NUM_FU, 6, number of producing functional units.
- N, 2, number of CDB lanes (superscalar width); 1 <= N <= NUM_FU.
- BUF_DEPTH, 2, entries per FU FIFO; power of two, >= 1.
- TAG_W, 6, physical-register tag width.
- DATA_W, 32, result data width.
- BMASK_W, 4, branch-mask width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fu_valid  in  NUM_FU  result offered by FU i.
- fu_tag  in  NUM_FU*TAG_W  destination tag, FU i at bits [i*TAG_W +: TAG_W].
- fu_data  in  NUM_FU*DATA_W  result value.
- fu_bmask  in  NUM_FU*BMASK_W  branch dependencies of the result.
- fu_ready  out  NUM_FU  FU i's FIFO can accept a push this cycle.
- b_mm_resolve  in  BMASK_W  one-hot mask of the branch resolving this cycle; zero means none.
- b_mm_mispred  in  1  the resolving branch mispredicted.
- cdb_valid  out  N  lane valid (registered).
- cdb_tag  out  N*TAG_W  lane tag (registered).
- cdb_data  out  N*DATA_W  lane data (registered).
- cdb_fu_id  out  N*$clog2(NUM_FU)  source FU of lane (registered).

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs empty; all entries invalid.
  - rr_ptr = 0.
  - cdb_valid = 0; cdb_tag, cdb_data and cdb_fu_id = 0.
  - fu_ready is all-ones in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all buffered results without broadcasting them.
- Push handshake:
  - A push occurs when fu_valid[i] && fu_ready[i].
  - fu_ready[i] = (count_i < BUF_DEPTH), computed from current state only; it does not see a same-cycle pop.
  - A push written at edge t is eligible for arbitration in cycle t+1. It appears on the CDB after edge t+1, i.e. 2-cycle latency from offer to broadcast.
- Push-time squash:
  - If b_mm_mispred && (incoming bmask & b_mm_resolve) != 0, the push is accepted (handshake completes) but not stored.
  - Otherwise the stored bmask is incoming bmask & ~b_mm_resolve.
- Stored-entry maintenance on resolve:
  - If b_mm_resolve != 0 and !b_mm_mispred, every stored bmask clears the resolve bit.
  - If b_mm_mispred, every stored entry whose bmask intersects b_mm_resolve is marked killed.
- Killed entries:
  - A killed FIFO head is popped in the cycle it is seen. This pop uses no grant slot and produces no CDB traffic.
  - At most one pop per FU per cycle, whether by grant or by kill.
- Arbitration (combinational, on current state):
  - Candidates are FUs whose head is valid and not killed.
  - Scan FU indices starting at rr_ptr, wrapping modulo NUM_FU. Grant the first up to N candidates.
  - Lane k receives the k-th granted FU in scan order. Unused lanes are invalid.
  - Granted heads pop at the clock edge.
  - rr_ptr becomes (last granted index + 1) mod NUM_FU. If nothing is granted, rr_ptr is unchanged.
- CDB register:
  - Granted entries are registered onto the lanes.
  - A granted entry whose bmask intersects b_mm_resolve while b_mm_mispred is set is registered with cdb_valid = 0. It is still popped.
  - Already-registered lanes are never retroactively cleared.
  - Tags are broadcast as stored; the bmask is internal only.
- Simultaneous push and pop on the same FU in one cycle: count is unchanged and pointers wrap modulo BUF_DEPTH.
- Full FIFO: fu_ready = 0 and the offered result is held by the FU. No loss and no overwrite.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - When FIFO i is empty and fu_valid[i] is high, the incoming result is a same-cycle arbitration candidate.
  - The push-time squash rule applies first.
  - If granted, the entry is broadcast after the next edge (1-cycle latency) and is never written to the FIFO.
  - If not granted, it is written to the FIFO as normal.
- Not defined: no bypass; latency is always at least 2 cycles.

Test Plan:
- Single result, NUM_FU=6, N=2: FU3 pushes tag 0x15, data 0xDEADBEEF, bmask 0 at cycle 1 -> cdb lane0 valid with tag 0x15 and data 0xDEADBEEF after edge 2 (after edge 1 if CDB_ARB_BYPASS_EN). Lane1 invalid.
- Round-robin fairness: all 6 FUs hold 2 entries each, rr_ptr = 0 -> grant pairs per cycle are {0,1},{2,3},{4,5},{0,1},{2,3},{4,5}. All 12 results are broadcast in 6 cycles with none duplicated.
- Backpressure, BUF_DEPTH=2, N=1: FUs 0 and 1 offer continuously -> fu_ready[0] drops after 2 unconsumed pushes. Throughput is 1 result per cycle, alternating FU0/FU1. No tag is lost.
- Mispredict squash: FU2 holds entries with bmask 0b0010 and 0b0000; assert b_mm_resolve = 0b0010 with b_mm_mispred = 1 -> the 0b0010 entry is never broadcast. The 0b0000 entry is broadcast, and a same-cycle push with bmask 0b0010 is dropped while fu_ready stays consistent.
- Correct resolve: entry with bmask 0b0100, resolve 0b0100 with mispred = 0 -> entry is broadcast later. A subsequent mispredict on 0b0100 (branch slot reused) does not kill it.
- Reset mid-operation: 5 entries buffered, reset asserted for 1 cycle -> cdb_valid = 0 for every cycle after the reset edge until new pushes arrive, fu_ready is all-ones, and rr_ptr = 0, so the first grant goes to FU0.

Source files
------------

// File: rtl/cdb_complete_arbiter.sv
// Result completion stage: per-FU FIFOs, N-lane round-robin CDB grant, branch squash.
// Optional same-cycle bypass of empty FIFOs is enabled with `define CDB_ARB_BYPASS_EN.
module cdb_complete_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int N         = 2,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int BMASK_W   = 4,
    localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]  fu_data,
    input  logic [NUM_FU*BMASK_W-1:0] fu_bmask,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [BMASK_W-1:0]        b_mm_resolve,
    input  logic                      b_mm_mispred,
    output logic [N-1:0]              cdb_valid,
    output logic [N*TAG_W-1:0]        cdb_tag,
    output logic [N*DATA_W-1:0]       cdb_data,
    output logic [N*FU_W-1:0]         cdb_fu_id
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [TAG_W-1:0]   q_tag  [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0]  q_data [NUM_FU][BUF_DEPTH];
    logic [BMASK_W-1:0] q_bm   [NUM_FU][BUF_DEPTH];
    logic [BUF_DEPTH-1:0] q_kill [NUM_FU];
    logic [PTR_W-1:0]   rd_ptr [NUM_FU];
    logic [PTR_W-1:0]   wr_ptr [NUM_FU];
    logic [CNT_W-1:0]   count  [NUM_FU];
    logic [FU_W-1:0]    rr_ptr;
    logic [FU_W-1:0]    rr_nxt;

    logic [TAG_W-1:0]   in_tag  [NUM_FU];
    logic [DATA_W-1:0]  in_data [NUM_FU];
    logic [BMASK_W-1:0] in_bm   [NUM_FU];
    logic [TAG_W-1:0]   s_tag   [NUM_FU];
    logic [DATA_W-1:0]  s_data  [NUM_FU];
    logic [BMASK_W-1:0] s_bm    [NUM_FU];
    logic [NUM_FU-1:0]  has_head;
    logic [NUM_FU-1:0]  head_kill;
    logic [NUM_FU-1:0]  push_sq;
    logic [NUM_FU-1:0]  cand;
    logic [NUM_FU-1:0]  from_in;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  write;

    logic [N-1:0]       lane_vld;
    logic [FU_W-1:0]    lane_fu [N];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_tag[i]    = fu_tag[i*TAG_W +: TAG_W];
            in_data[i]   = fu_data[i*DATA_W +: DATA_W];
            in_bm[i]     = fu_bmask[i*BMASK_W +: BMASK_W];
            has_head[i]  = (count[i] != '0);
            head_kill[i] = has_head[i] && q_kill[i][rd_ptr[i]];
            fu_ready[i]  = (count[i] < CNT_W'(BUF_DEPTH));
            push_sq[i]   = b_mm_mispred && ((in_bm[i] & b_mm_resolve) != '0);
`ifdef CDB_ARB_BYPASS_EN
            // An empty FIFO lets its incoming result compete this very cycle.
            from_in[i] = !has_head[i];
            cand[i]    = (has_head[i] && !head_kill[i])
                       || (!has_head[i] && fu_valid[i] && !push_sq[i]);
`else
            from_in[i] = 1'b0;
            cand[i]    = has_head[i] && !head_kill[i];
`endif
            s_tag[i]  = from_in[i] ? in_tag[i]  : q_tag[i][rd_ptr[i]];
            s_data[i] = from_in[i] ? in_data[i] : q_data[i][rd_ptr[i]];
            s_bm[i]   = from_in[i] ? in_bm[i]   : q_bm[i][rd_ptr[i]];
        end
    end

    // Lane k takes the first candidate in scan order not already taken by a lower lane.
    always_comb begin
        logic [FU_W:0]   sum;
        logic [FU_W-1:0] idx;
        logic            found;
        grant    = '0;
        lane_vld = '0;
        rr_nxt   = rr_ptr;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            lane_fu[k] = '0;
            found      = 1'b0;
            for (int j = 0; j < NUM_FU; j++) begin
                sum = {1'b0, rr_ptr} + (FU_W+1)'(j);
                if (sum >= (FU_W+1)'(NUM_FU))
                    sum = sum - (FU_W+1)'(NUM_FU);
                idx = sum[FU_W-1:0];
                if (!found && cand[idx] && !grant[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    lane_vld[k] = 1'b1;
                    lane_fu[k]  = idx;
                    rr_nxt = (idx == FU_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i]   = has_head[i] && (grant[i] || head_kill[i]);
            write[i] = fu_valid[i] && fu_ready[i] && !push_sq[i]
                     && !(grant[i] && from_in[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                q_kill[i] <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_fu_id <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                for (int e = 0; e < BUF_DEPTH; e++) begin
                    if (b_mm_resolve != '0 && !b_mm_mispred)
                        q_bm[i][e] <= q_bm[i][e] & ~b_mm_resolve;
                    if (b_mm_mispred && (q_bm[i][e] & b_mm_resolve) != '0)
                        q_kill[i][e] <= 1'b1;
                end
                if (write[i]) begin
                    q_tag[i][wr_ptr[i]]  <= in_tag[i];
                    q_data[i][wr_ptr[i]] <= in_data[i];
                    q_bm[i][wr_ptr[i]]   <= in_bm[i] & ~b_mm_resolve;
                    q_kill[i][wr_ptr[i]] <= 1'b0;
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i])
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (write[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (!write[i] && pop[i])
                    count[i] <= count[i] - 1'b1;
            end
            rr_ptr <= rr_nxt;
            for (int k = 0; k < N; k++) begin
                cdb_valid[k] <= lane_vld[k] && !(b_mm_mispred
                    && (s_bm[lane_fu[k]] & b_mm_resolve) != '0);
                cdb_tag[k*TAG_W +: TAG_W]    <= lane_vld[k] ? s_tag[lane_fu[k]] : '0;
                cdb_data[k*DATA_W +: DATA_W] <= lane_vld[k] ? s_data[lane_fu[k]] : '0;
                cdb_fu_id[k*FU_W +: FU_W]    <= lane_fu[k];
            end
        end
    end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Randomized bench for cdb_complete_arbiter against a queue-based reference model.
module tb_cdb_complete_arbiter;

    localparam int NUM_FU = 6, N = 2, BUF_DEPTH = 2;
    localparam int TAG_W = 6, DATA_W = 32, BMASK_W = 4, FU_W = 3;
`ifdef CDB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU*TAG_W-1:0]   fu_tag;
    logic [NUM_FU*DATA_W-1:0]  fu_data;
    logic [NUM_FU*BMASK_W-1:0] fu_bmask;
    logic [NUM_FU-1:0]         fu_ready;
    logic [BMASK_W-1:0]        b_mm_resolve;
    logic                      b_mm_mispred;
    logic [N-1:0]              cdb_valid;
    logic [N*TAG_W-1:0]        cdb_tag;
    logic [N*DATA_W-1:0]       cdb_data;
    logic [N*FU_W-1:0]         cdb_fu_id;

    always #5 clock = ~clock;

    cdb_complete_arbiter #(
        .NUM_FU(NUM_FU), .N(N), .BUF_DEPTH(BUF_DEPTH),
        .TAG_W(TAG_W), .DATA_W(DATA_W), .BMASK_W(BMASK_W)
    ) dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
        .fu_bmask(fu_bmask), .fu_ready(fu_ready),
        .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_fu_id(cdb_fu_id)
    );

    typedef struct {
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
        logic [BMASK_W-1:0] bm;
        bit                 kill;
    } ent_t;

    ent_t q [NUM_FU][$];
    int   rr;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        fu_valid     = '0;
        b_mm_resolve = '0;
        b_mm_mispred = 1'b0;
    endtask

    task automatic offer(input int i, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d, input logic [BMASK_W-1:0] m);
        fu_valid[i] = 1'b1;
        fu_tag[i*TAG_W +: TAG_W]       = t;
        fu_data[i*DATA_W +: DATA_W]    = d;
        fu_bmask[i*BMASK_W +: BMASK_W] = m;
    endtask

    // Predict one clock edge from the current inputs, then check the DUT after it.
    task automatic step();
        logic [NUM_FU-1:0] er;
        bit   ev [N];
        logic [TAG_W-1:0]  et [N];
        logic [DATA_W-1:0] ed [N];
        int   ef [N];
        bit   gr [NUM_FU];
        bit   byp [NUM_FU];
        int   ng, last, i;
        ent_t c;
        logic [BMASK_W-1:0] ibm;
        bit   isq, take;
        for (int f = 0; f < NUM_FU; f++) begin
            er[f]  = (q[f].size() < BUF_DEPTH);
            gr[f]  = 0;
            byp[f] = 0;
        end
        chk("fu_ready", 64'(fu_ready), 64'(er));
        for (int k = 0; k < N; k++) begin
            ev[k] = 0; et[k] = '0; ed[k] = '0; ef[k] = 0;
        end
        ng = 0;
        last = 0;
        if (!reset) begin
            for (int j = 0; j < NUM_FU; j++) begin
                i    = (rr + j) % NUM_FU;
                ibm  = fu_bmask[i*BMASK_W +: BMASK_W];
                isq  = b_mm_mispred && ((ibm & b_mm_resolve) != '0);
                take = 0;
                if (ng < N) begin
                    if (q[i].size() > 0 && !q[i][0].kill) begin
                        c = q[i][0];
                        take = 1;
                    end else if (BYP && q[i].size() == 0 && fu_valid[i] && !isq) begin
                        c.tag  = fu_tag[i*TAG_W +: TAG_W];
                        c.data = fu_data[i*DATA_W +: DATA_W];
                        c.bm   = ibm;
                        c.kill = 0;
                        take   = 1;
                        byp[i] = 1;
                    end
                end
                if (take) begin
                    ev[ng] = !(b_mm_mispred && ((c.bm & b_mm_resolve) != '0));
                    et[ng] = c.tag;
                    ed[ng] = c.data;
                    ef[ng] = i;
                    gr[i]  = 1;
                    last   = i;
                    ng++;
                end
            end
            if (ng > 0)
                rr = (last + 1) % NUM_FU;
            for (int f = 0; f < NUM_FU; f++) begin
                ibm = fu_bmask[f*BMASK_W +: BMASK_W];
                isq = b_mm_mispred && ((ibm & b_mm_resolve) != '0);
                if (q[f].size() > 0 && (gr[f] || q[f][0].kill))
                    void'(q[f].pop_front());
                foreach (q[f][e]) begin
                    if (b_mm_resolve != '0 && !b_mm_mispred)
                        q[f][e].bm = q[f][e].bm & ~b_mm_resolve;
                    if (b_mm_mispred && (q[f][e].bm & b_mm_resolve) != '0)
                        q[f][e].kill = 1;
                end
                if (fu_valid[f] && er[f] && !isq && !byp[f]) begin
                    c.tag  = fu_tag[f*TAG_W +: TAG_W];
                    c.data = fu_data[f*DATA_W +: DATA_W];
                    c.bm   = ibm & ~b_mm_resolve;
                    c.kill = 0;
                    q[f].push_back(c);
                end
            end
        end else begin
            for (int f = 0; f < NUM_FU; f++)
                q[f].delete();
            rr = 0;
        end
        @(posedge clock);
        #1;
        if (reset) begin
            chk("rst_valid", 64'(cdb_valid), 64'd0);
            chk("rst_tag", 64'(cdb_tag), 64'd0);
            chk("rst_data", 64'(cdb_data), 64'd0);
            chk("rst_fu_id", 64'(cdb_fu_id), 64'd0);
        end else begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("lane%0d_valid", k), 64'(cdb_valid[k]), 64'(ev[k]));
                if (ev[k]) begin
                    chk($sformatf("lane%0d_tag", k),
                        64'(cdb_tag[k*TAG_W +: TAG_W]), 64'(et[k]));
                    chk($sformatf("lane%0d_data", k),
                        64'(cdb_data[k*DATA_W +: DATA_W]), 64'(ed[k]));
                    chk($sformatf("lane%0d_fu", k),
                        64'(cdb_fu_id[k*FU_W +: FU_W]), 64'(ef[k]));
                end
            end
        end
    endtask

    initial begin
        rr = 0;
        fu_tag = '0;
        fu_data = '0;
        fu_bmask = '0;
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        idle();
        step();

        // Single result from FU3.
        offer(3, 6'h15, 32'hDEADBEEF, 4'b0000);
        step();
        idle();
        if (BYP) begin
            chk("single_valid", 64'(cdb_valid), 64'd1);
            chk("single_tag", 64'(cdb_tag[TAG_W-1:0]), 64'h15);
            chk("single_data", 64'(cdb_data[DATA_W-1:0]), 64'hDEADBEEF);
        end
        step();
        if (!BYP) begin
            chk("single_valid", 64'(cdb_valid), 64'd1);
            chk("single_tag", 64'(cdb_tag[TAG_W-1:0]), 64'h15);
            chk("single_data", 64'(cdb_data[DATA_W-1:0]), 64'hDEADBEEF);
        end
        repeat (2) step();

        // Every FU offers twice back to back; round-robin drains them.
        for (int r = 0; r < 2; r++) begin
            for (int f = 0; f < NUM_FU; f++)
                offer(f, 6'(r * 8 + f), 32'(32'hA000 + r * 16 + f), 4'b0000);
            step();
        end
        idle();
        repeat (8) step();

        // FU0 and FU1 offer continuously.
        for (int r = 0; r < 10; r++) begin
            offer(0, 6'(r), 32'(r), 4'b0000);
            offer(1, 6'(32 + r), 32'(100 + r), 4'b0000);
            step();
        end
        idle();
        repeat (4) step();

        // Mispredict on branch 0b0010 while FU2 holds/offers dependent results.
        offer(2, 6'h21, 32'h1, 4'b0010);
        offer(4, 6'h22, 32'h2, 4'b0010);
        step();
        idle();
        offer(2, 6'h23, 32'h3, 4'b0000);
        step();
        idle();
        offer(2, 6'h24, 32'h4, 4'b0010);
        b_mm_resolve = 4'b0010;
        b_mm_mispred = 1'b1;
        step();
        idle();
        repeat (3) step();

        // Correct resolve of 0b0100, then a reused-slot mispredict on 0b0100.
        for (int f = 0; f < NUM_FU; f++)
            offer(f, 6'(40 + f), 32'(f), 4'b0100);
        step();
        idle();
        b_mm_resolve = 4'b0100;
        step();
        b_mm_mispred = 1'b1;
        step();
        idle();
        repeat (4) step();

        // Reset in the middle of traffic.
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < NUM_FU; f++)
                offer(f, 6'(r * 6 + f), 32'(r), 4'b0000);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_ready", 64'(fu_ready), 64'h3F);
        chk("post_rst_valid", 64'(cdb_valid), 64'd0);
        for (int f = 0; f < NUM_FU; f++)
            offer(f, 6'(50 + f), 32'(f), 4'b0000);
        step();
        idle();
        if (BYP)
            chk("post_rst_first", 64'(cdb_fu_id[FU_W-1:0]), 64'd0);
        step();
        if (!BYP)
            chk("post_rst_first", 64'(cdb_fu_id[FU_W-1:0]), 64'd0);
        repeat (6) step();

        // Randomized traffic with resolves and mispredicts.
        for (int n = 0; n < 800; n++) begin
            idle();
            for (int f = 0; f < NUM_FU; f++)
                if ($urandom_range(0, 99) < 45)
                    offer(f, 6'($urandom), $urandom,
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
            if ($urandom_range(0, 3) == 0) begin
                b_mm_resolve = 4'(1 << $urandom_range(0, BMASK_W - 1));
                b_mm_mispred = $urandom_range(0, 1) == 1;
            end
            step();
        end
        idle();
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
